// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares SRAM port a between m0 and m1, with an optional zero-fill after reset
// Grants are combinational; read data returns one cycle after the grant and holds until the next read.
module sram_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 256,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int MODE         = 0,
  parameter int STARVE_LIMIT = 4,
  parameter int INIT_CLEAR   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0]      m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [WIDTH-1:0]      m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0]      m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [WIDTH-1:0]      m1_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [WIDTH-1:0]      sram_wdata,
  output logic                  sram_we,
  input  logic [WIDTH-1:0]      sram_rdata,
  output logic                  init_done
);
  typedef enum logic {CLEAR, RUN} state_t;
  localparam state_t                RESET_STATE = (INIT_CLEAR != 0) ? CLEAR : RUN;
  localparam logic [3:0]            LIMIT       = 4'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  last_q, last_d;
  logic [3:0]            starve_q, starve_d;
  logic                  m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic [WIDTH-1:0]      m0_hold_q, m0_hold_d, m1_hold_q, m1_hold_d;
  logic                  clear, run, pick_m1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == CLEAR && clr_cnt_q == LAST_ADDR) ? RUN : state_q;
  end
  // Reset gates every strobe so nothing reaches the SRAM while rst_n is low.
  always_comb begin
    clear      = rst_n && state_q == CLEAR;
    run        = rst_n && state_q == RUN;
    pick_m1    = (MODE == 0) ? !last_q : (starve_q == LIMIT);
    m1_gnt     = run && m1_req && (!m0_req || pick_m1);
    m0_gnt     = run && m0_req && !m1_gnt;
    sram_we    = clear || (m0_gnt && m0_we) || (m1_gnt && m1_we);
    sram_addr  = clear ? clr_cnt_q : m1_gnt ? m1_addr : m0_gnt ? m0_addr : addr_q;
    sram_wdata = clear ? '0 : m1_gnt ? m1_wdata : m0_wdata;
    m0_rvalid  = m0_rvalid_q;
    m1_rvalid  = m1_rvalid_q;
    m0_rdata   = m0_rvalid_q ? sram_rdata : m0_hold_q;
    m1_rdata   = m1_rvalid_q ? sram_rdata : m1_hold_q;
    init_done  = state_q == RUN;
  end
  always_comb begin
    clr_cnt_d   = clear ? clr_cnt_q + ADDR_WIDTH'(1) : clr_cnt_q;
    addr_d      = sram_addr;
    last_d      = m1_gnt ? 1'b1 : m0_gnt ? 1'b0 : last_q;
    starve_d    = (MODE == 0 || !run) ? starve_q :
                  (!m1_req || m1_gnt) ? 4'd0 :
                  (starve_q == 4'hf) ? starve_q : starve_q + 4'd1;
    m0_rvalid_d = m0_gnt && !m0_we;
    m1_rvalid_d = m1_gnt && !m1_we;
    m0_hold_d   = m0_rdata;
    m1_hold_d   = m1_rdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_q   <= '0;
      addr_q      <= '0;
      last_q      <= 1'b1;
      starve_q    <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_hold_q   <= '0;
      m1_hold_q   <= '0;
    end else begin
      clr_cnt_q   <= clr_cnt_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      starve_q    <= starve_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_hold_q   <= m0_hold_d;
      m1_hold_q   <= m1_hold_d;
    end
  end
endmodule
